// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the load/store unit: FSM state encodings, the
// STORE_*/LOAD_* encodings used by the main decoder, byte-enable constants,
// and small helpers that classify an access by size and alignment.
// No ports.

package load_store_unit_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Store width encodings from the decoder (2'b11 behaves as sw)
    localparam logic [1:0] STORE_SW = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SB = 2'b10;

    // Load type encodings from the decoder (3'b101..3'b111 behave as lw)
    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b011;
    localparam logic [2:0] LOAD_LHU = 3'b100;

    // Byte-enable patterns
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    function automatic access_size_e store_size(input logic [1:0] store);
        case (store)
            STORE_SW: return SIZE_WORD;
            STORE_SH: return SIZE_HALF;
            STORE_SB: return SIZE_BYTE;
            default:  return SIZE_WORD;
        endcase
    endfunction

    function automatic access_size_e load_size(input logic [2:0] load);
        case (load)
            LOAD_LB, LOAD_LBU: return SIZE_BYTE;
            LOAD_LH, LOAD_LHU: return SIZE_HALF;
            LOAD_LW:           return SIZE_WORD;
            default:           return SIZE_WORD;
        endcase
    endfunction

    function automatic logic load_unsigned(input logic [2:0] load);
        return (load == LOAD_LBU) || (load == LOAD_LHU);
    endfunction

    // Writes take priority when the decoder asserts both controls
    function automatic access_size_e access_size(input logic       we,
                                                 input logic [1:0] store,
                                                 input logic [2:0] load);
        return we ? store_size(store) : load_size(load);
    endfunction

    function automatic logic is_misaligned(input access_size_e size,
                                           input logic [1:0]   addr_lo);
        case (size)
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// load_store_unit_lane_align
// Purely combinational lane logic for the load/store unit: byte enables and
// lane-replicated write data for the bus request, and lane selection with
// sign/zero extension for returned read data.
// Ports:
//   we          in   1   access is a store
//   store       in   2   store width encoding
//   load        in   3   load type encoding
//   addr_lo     in   2   low byte-address bits of the access
//   wdata       in   32  raw store data (rs2)
//   rdata       in   32  raw bus read word
//   be          out  4   byte enables for the request
//   wdata_lanes out  32  store data replicated onto every lane
//   rdata_ext   out  32  selected and extended load result

module load_store_unit_lane_align
    import load_store_unit_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  store,
    input  logic [2:0]  load,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    access_size_e size;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic         sign_ext;

    assign size     = access_size(we, store, load);
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    // Halfwords look at addr[1] only, so an odd address picks its containing half
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign sign_ext = !load_unsigned(load);

    // Word accesses ignore addr_lo entirely; narrower ones replicate data so
    // the memory only needs the byte enables to pick the right lane.
    always_comb begin
        be          = BE_WORD;
        wdata_lanes = wdata;
        case (size)
            SIZE_BYTE: begin
                be          = BE_BYTE0 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be          = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_ext = rdata;
        case (load_size(load))
            SIZE_BYTE: rdata_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: rdata_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:   rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle data-memory access stage. Accepts one decoded load or store
// from the core, runs a single valid/ready bus transaction for it, and pulses
// done when finished. ls_ready is high only while idle, which stalls the core.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses finish immediately with fault=1 and never reach the bus.
// Parameters:
//   ADDR_W   byte-address width
//   TIMEOUT  cycles allowed in REQ or RESP before abort (0 disables)
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ls_valid/ls_ready          core handshake
//   mem_write, mem_read        decoded access controls
//   store, load                width/extension encodings
//   addr, wdata                ALU address and rs2 data
//   done, rdata_out, fault     completion pulse, load result, error flag
//   bus_valid/bus_ready        request handshake
//   bus_we, bus_addr, bus_be, bus_wdata  request payload
//   bus_rvalid, bus_rdata      read response

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        store,
    input  logic [2:0]        load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata_out,
    output logic              fault,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    // Counter only has to reach TIMEOUT-1
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [1:0]        store_q;
    logic [2:0]        load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              fault_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              in_req;
    logic              timeout_hit;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

    load_store_unit_lane_align u_lane_align (
        .we          (we_q),
        .store       (store_q),
        .load        (load_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (bus_rdata),
        .be          (lane_be),
        .wdata_lanes (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    assign ls_ready = (state_q == ST_IDLE);
    assign accept   = ls_valid & ls_ready & (mem_read | mem_write);
    assign in_req   = (state_q == ST_REQ);

    // The counter starts at 0 in the first cycle of REQ/RESP, so the cycle
    // holding CNT_LAST is the TIMEOUT-th cycle spent waiting.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_trap;
    assign misalign_trap = is_misaligned(access_size(mem_write, store, load), addr[1:0]);
`endif

    // Bus outputs decode straight from state so an async reset drops
    // bus_valid at once; payload is zero whenever no request is live.
    assign bus_valid = in_req;
    assign bus_we    = in_req & we_q;
    assign bus_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be    = in_req ? lane_be : 4'b0000;
    assign bus_wdata = (in_req & we_q) ? lane_wdata : 32'd0;

    assign done      = (state_q == ST_DONE);
    assign fault     = done & fault_q;
    assign rdata_out = rdata_q;

    // Main FSM plus the operation latches. rdata_q is cleared on accept so a
    // store or aborted access reports zero, and otherwise holds the last load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            store_q <= STORE_SW;
            load_q  <= LOAD_LB;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= mem_write;
                        store_q <= store;
                        load_q  <= load;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rdata_q <= 32'd0;
                        cnt_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        fault_q <= misalign_trap;
                        state_q <= misalign_trap ? ST_DONE : ST_REQ;
`else
                        fault_q <= 1'b0;
                        state_q <= ST_REQ;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus_ready) begin
                        cnt_q   <= '0;
                        state_q <= we_q ? ST_DONE : ST_RESP;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus_rvalid) begin
                        rdata_q <= lane_rdata;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit (TIMEOUT=8). Each access pushes its
// expected result, fault flag and latency into a scoreboard queue; the entry
// is popped and compared when done pulses. A small inline bus responder
// drives bus_ready/bus_rvalid with configurable wait states.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-access expectations.

module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TIMEOUT    = 8;
    localparam int MAX_CYCLES = 40;

    logic        clk;
    logic        rst_n;
    logic        ls_valid;
    logic        ls_ready;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  store;
    logic [2:0]  load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata_out;
    logic        fault;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   errors;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ls_valid   (ls_valid),
        .ls_ready   (ls_ready),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .store      (store),
        .load       (load),
        .addr       (addr),
        .wdata      (wdata),
        .done       (done),
        .rdata_out  (rdata_out),
        .fault      (fault),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // bus_mask: bit0 checks addr/we, bit1 be, bit2 wdata on every REQ cycle
    task automatic applyStimulus(
        input string       name,
        input logic        we,
        input logic        re,
        input logic [1:0]  st,
        input logic [2:0]  ld,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          ready_delay,
        input int          rvalid_delay,
        input logic [31:0] rdata_bus,
        input logic [31:0] exp_rdata,
        input logic        exp_fault,
        input int          exp_lat,
        input int          bus_mask,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_addr,
        input logic [31:0] exp_wdata,
        input logic        no_bus
    );
        exp_t e;
        int   lat;
        int   req_n;
        int   resp_n;
        logic in_resp;
        logic saw_valid;
        sb_q.push_back('{rdata: exp_rdata, fault: exp_fault, lat: exp_lat});
        ls_valid  = 1'b1;
        mem_write = we;
        mem_read  = re;
        store     = st;
        load      = ld;
        addr      = a;
        wdata     = wd;
        @(posedge clk); #1;
        ls_valid  = 1'b0;
        lat       = 1;
        req_n     = 0;
        resp_n    = 0;
        in_resp   = 1'b0;
        saw_valid = 1'b0;
        while (!done && lat < MAX_CYCLES) begin
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = 32'hDEADBEEF;
            if (bus_valid) begin
                saw_valid = 1'b1;
                if (bus_mask[0]) begin
                    checkOutput({name, "_addr"}, bus_addr, exp_addr);
                    checkOutput({name, "_we"}, 32'(bus_we), 32'(we));
                end
                if (bus_mask[1]) checkOutput({name, "_be"}, 32'(bus_be), 32'(exp_be));
                if (bus_mask[2]) checkOutput({name, "_wdata"}, bus_wdata, exp_wdata);
                if (req_n >= ready_delay) begin
                    bus_ready  = 1'b1;
                    // rvalid alongside ready carries junk and must be ignored
                    bus_rvalid = 1'b1;
                    in_resp    = !we;
                end
                req_n++;
            end else if (in_resp) begin
                if (resp_n >= rvalid_delay) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata_bus;
                end
                resp_n++;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        e = sb_q.pop_front();
        checkOutput({name, "_done_seen"}, 32'(done), 32'd1);
        checkOutput({name, "_latency"}, 32'(lat), 32'(e.lat));
        checkOutput({name, "_rdata"}, rdata_out, e.rdata);
        checkOutput({name, "_fault"}, 32'(fault), 32'(e.fault));
        checkOutput({name, "_ready_in_done"}, 32'(ls_ready), 32'd0);
        if (no_bus) checkOutput({name, "_no_bus"}, 32'(saw_valid), 32'd0);
        // A request presented while in DONE must not be taken
        ls_valid  = 1'b1;
        mem_write = 1'b1;
        mem_read  = 1'b0;
        @(posedge clk); #1;
        ls_valid  = 1'b0;
        mem_write = 1'b0;
        checkOutput({name, "_idle_after"}, 32'(ls_ready), 32'd1);
        checkOutput({name, "_no_accept_done"}, 32'(bus_valid), 32'd0);
        checkOutput({name, "_rdata_hold"}, rdata_out, e.rdata);
        checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        ls_valid   = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        store      = STORE_SW;
        load       = LOAD_LB;
        addr       = 32'd0;
        wdata      = 32'd0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ls_ready", 32'(ls_ready), 32'd1);
        checkOutput("rst_bus_valid", 32'(bus_valid), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rdata", rdata_out, 32'd0);
        checkOutput("rst_be", 32'(bus_be), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // name, we, re, store, load, addr, wdata, rdly, vdly, busdata, exp_rdata, fault, lat, mask, be, baddr, bwdata, nobus
        applyStimulus("sb", 1'b1, 1'b0, STORE_SB, LOAD_LB, 32'h103, 32'hAABBCCDD, 0, 0, 32'h0,
                      32'h0, 1'b0, 2, 7, 4'b1000, 32'h100, 32'hDDDDDDDD, 1'b0);
        applyStimulus("lb", 1'b0, 1'b1, STORE_SW, LOAD_LB, 32'h102, 32'h0, 0, 0, 32'h0080FF00,
                      32'hFFFFFF80, 1'b0, 3, 1, 4'b0, 32'h100, 32'h0, 1'b0);
        applyStimulus("lbu", 1'b0, 1'b1, STORE_SW, LOAD_LBU, 32'h102, 32'h0, 0, 0, 32'h0080FF00,
                      32'h00000080, 1'b0, 3, 1, 4'b0, 32'h100, 32'h0, 1'b0);
        applyStimulus("lhu", 1'b0, 1'b1, STORE_SW, LOAD_LHU, 32'h6, 32'h0, 0, 0, 32'h80011234,
                      32'h00008001, 1'b0, 3, 1, 4'b0, 32'h4, 32'h0, 1'b0);
        applyStimulus("lh", 1'b0, 1'b1, STORE_SW, LOAD_LH, 32'h6, 32'h0, 0, 2, 32'h80011234,
                      32'hFFFF8001, 1'b0, 5, 1, 4'b0, 32'h4, 32'h0, 1'b0);
        applyStimulus("sh", 1'b1, 1'b0, STORE_SH, LOAD_LB, 32'h2, 32'h1234ABCD, 0, 0, 32'h0,
                      32'h0, 1'b0, 2, 7, 4'b1100, 32'h0, 32'hABCDABCD, 1'b0);
        applyStimulus("sw_wait", 1'b1, 1'b0, STORE_SW, LOAD_LB, 32'h200, 32'h13579BDF, 5, 0, 32'h0,
                      32'h0, 1'b0, 7, 7, 4'b1111, 32'h200, 32'h13579BDF, 1'b0);
        applyStimulus("lw_wait", 1'b0, 1'b1, STORE_SW, LOAD_LW, 32'h10, 32'h0, 1, 1, 32'hCAFEF00D,
                      32'hCAFEF00D, 1'b0, 5, 3, 4'b1111, 32'h10, 32'h0, 1'b0);
        applyStimulus("ld110", 1'b0, 1'b1, STORE_SW, 3'b110, 32'h20, 32'h0, 0, 0, 32'h89ABCDEF,
                      32'h89ABCDEF, 1'b0, 3, 3, 4'b1111, 32'h20, 32'h0, 1'b0);
        applyStimulus("st11", 1'b1, 1'b0, 2'b11, LOAD_LB, 32'h24, 32'h0F1E2D3C, 0, 0, 32'h0,
                      32'h0, 1'b0, 2, 7, 4'b1111, 32'h24, 32'h0F1E2D3C, 1'b0);
        applyStimulus("wr_wins", 1'b1, 1'b1, STORE_SB, LOAD_LW, 32'h31, 32'h0000005A, 0, 0, 32'h0,
                      32'h0, 1'b0, 2, 7, 4'b0010, 32'h30, 32'h5A5A5A5A, 1'b0);
        applyStimulus("to_req", 1'b1, 1'b0, STORE_SW, LOAD_LB, 32'h40, 32'h11111111, 1000, 0, 32'h0,
                      32'h0, 1'b1, TIMEOUT + 1, 1, 4'b0, 32'h40, 32'h0, 1'b0);
        applyStimulus("lw_prime", 1'b0, 1'b1, STORE_SW, LOAD_LW, 32'h44, 32'h0, 0, 0, 32'h77665544,
                      32'h77665544, 1'b0, 3, 0, 4'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus("to_resp", 1'b0, 1'b1, STORE_SW, LOAD_LW, 32'h48, 32'h0, 0, 1000, 32'h12345678,
                      32'h0, 1'b1, TIMEOUT + 2, 1, 4'b0, 32'h48, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus("lw_mis", 1'b0, 1'b1, STORE_SW, LOAD_LW, 32'h5, 32'h0, 0, 0, 32'h11223344,
                      32'h0, 1'b1, 1, 0, 4'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus("sh_mis", 1'b1, 1'b0, STORE_SH, LOAD_LB, 32'h3, 32'h0000BEEF, 0, 0, 32'h0,
                      32'h0, 1'b1, 1, 0, 4'b0, 32'h0, 32'h0, 1'b1);
`else
        applyStimulus("lw_mis", 1'b0, 1'b1, STORE_SW, LOAD_LW, 32'h5, 32'h0, 0, 0, 32'h11223344,
                      32'h11223344, 1'b0, 3, 3, 4'b1111, 32'h4, 32'h0, 1'b0);
        applyStimulus("sh_mis", 1'b1, 1'b0, STORE_SH, LOAD_LB, 32'h3, 32'h0000BEEF, 0, 0, 32'h0,
                      32'h0, 1'b0, 2, 7, 4'b1100, 32'h0, 32'hBEEFBEEF, 1'b0);
`endif

        // ls_valid without mem_read/mem_write is not an access
        ls_valid = 1'b1;
        @(posedge clk); #1;
        ls_valid = 1'b0;
        checkOutput("nop_ready", 32'(ls_ready), 32'd1);
        checkOutput("nop_bus_valid", 32'(bus_valid), 32'd0);

        // Reset while waiting in REQ: bus_valid must drop without a clock edge
        ls_valid  = 1'b1;
        mem_write = 1'b1;
        store     = STORE_SW;
        addr      = 32'h300;
        wdata     = 32'hA5A5A5A5;
        @(posedge clk); #1;
        ls_valid  = 1'b0;
        mem_write = 1'b0;
        checkOutput("rreq_valid_pre", 32'(bus_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rreq_valid_async", 32'(bus_valid), 32'd0);
        checkOutput("rreq_ready_async", 32'(ls_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while in RESP, then a late rvalid in IDLE must be ignored
        ls_valid = 1'b1;
        mem_read = 1'b1;
        load     = LOAD_LW;
        addr     = 32'h400;
        @(posedge clk); #1;
        ls_valid  = 1'b0;
        mem_read  = 1'b0;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        checkOutput("rresp_in_resp", 32'(ls_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("rresp_ready_async", 32'(ls_ready), 32'd1);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h55AA55AA;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput("late_rvalid_done", 32'(done), 32'd0);
            checkOutput("late_rvalid_rdata", rdata_out, 32'd0);
        end
        bus_rvalid = 1'b0;

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
